// File: rtl/led_sequencer.sv
// led_sequencer: command-driven LED controller with off, solid, blink and N-pulse burst modes
module led_sequencer #(
    parameter int TICK_DIV = 1000000,
    parameter int PER_W    = 8,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [PER_W-1:0] cmd_period,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             busy,
    output logic             done,
    output logic             led
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    typedef enum logic [2:0] {IDLE, SOLID, BLK_HI, BLK_LO, BST_HI, BST_LO} state_t;
    state_t state;
    logic [PW-1:0] pre;
    logic [PER_W-1:0] phase, per, eff;
    logic [CNT_W-1:0] pcnt;
    logic tick, last, accept;
    assign cmd_ready = !rst && state != BST_HI && state != BST_LO;
    assign accept = cmd_valid && cmd_ready;
    assign tick = pre == PMAX;
    assign eff = per == '0 ? PER_W'(1) : per;
    assign last = tick && phase == eff - 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            led   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
            pre   <= '0;
            phase <= '0;
            pcnt  <= '0;
            per   <= '0;
        end else begin
            done <= 1'b0;
            pre  <= tick ? '0 : pre + 1'b1;
            if (accept) begin
                pre   <= '0;
                phase <= '0;
                per   <= cmd_period;
                pcnt  <= cmd_count;
                case (cmd_mode)
                    2'd0: begin state <= IDLE; led <= 1'b0; end
                    2'd1: begin state <= SOLID; led <= 1'b1; end
                    2'd2: begin state <= BLK_HI; led <= 1'b1; end
                    default: begin
                        state <= cmd_count != '0 ? BST_HI : IDLE;
                        led   <= cmd_count != '0;
                        busy  <= cmd_count != '0;
                        done  <= cmd_count == '0;
                    end
                endcase
            end else if (tick) begin
                phase <= last ? '0 : phase + 1'b1;
                if (last) begin
                    case (state)
                        BLK_HI: begin state <= BLK_LO; led <= 1'b0; end
                        BLK_LO: begin state <= BLK_HI; led <= 1'b1; end
                        BST_HI: begin state <= BST_LO; led <= 1'b0; pcnt <= pcnt - 1'b1; end
                        BST_LO: begin
                            state <= pcnt != '0 ? BST_HI : IDLE;
                            led   <= pcnt != '0;
                            busy  <= pcnt != '0;
                            done  <= pcnt == '0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed and random stimulus against a time-since-command reference model
module tb_led_sequencer;
    localparam int TD = 2;
    logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
    logic cmd_ready, busy, done, led;
    logic [1:0] cmd_mode = 2'd0;
    logic [7:0] cmd_period = 8'd0, cmd_count = 8'd0;
    int checks = 0, errors = 0;
    int m = 0, e = 1, c = 0, t = 0;

    always #5 clk = ~clk;

    led_sequencer #(.TICK_DIV(TD), .PER_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_period(cmd_period), .cmd_count(cmd_count),
        .busy(busy), .done(done), .led(led)
    );

    // Model: m = last accepted mode, t = cycles since it took effect, n = interval index
    function automatic int nidx();
        return t > 0 ? (t - 1) / (e * TD) : 0;
    endfunction
    function automatic logic exp_busy();
        return m == 3 && nidx() < 2 * c;
    endfunction
    function automatic logic exp_led();
        return m == 1 || (m == 2 && nidx() % 2 == 0) || (exp_busy() && nidx() % 2 == 0);
    endfunction
    function automatic logic exp_done();
        return m == 3 && t - 1 == 2 * c * e * TD;
    endfunction
    function automatic logic exp_ready();
        return !rst && !exp_busy();
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d mode=%0d observed=%b expected=%b", tag, t, m, obs, exp);
        end
    endtask

    task automatic step();
        logic acc;
        acc = cmd_valid && exp_ready();
        @(posedge clk);
        if (rst) begin
            m = 0;
            t = 0;
        end else if (acc) begin
            m = int'(cmd_mode);
            e = cmd_period == 8'd0 ? 1 : int'(cmd_period);
            c = int'(cmd_count);
            t = 1;
        end else begin
            t++;
        end
        #1;
        chk("led", led, exp_led());
        chk("busy", busy, exp_busy());
        chk("done", done, exp_done());
        chk("cmd_ready", cmd_ready, exp_ready());
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic issue(input logic [1:0] md, input logic [7:0] p, input logic [7:0] n);
        cmd_valid = 1'b1;
        cmd_mode = md;
        cmd_period = p;
        cmd_count = n;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(2);
        issue(2'd2, 8'd3, 8'd0);
        run(50);
        issue(2'd3, 8'd1, 8'd3);
        run(14);
        issue(2'd3, 8'd5, 8'd0);
        run(3);
        issue(2'd2, 8'd0, 8'd0);
        run(12);
        issue(2'd2, 8'd5, 8'd0);
        run(13);
        issue(2'd1, 8'd0, 8'd0);
        run(10);
        issue(2'd3, 8'd1, 8'd2);
        cmd_valid = 1'b1;
        cmd_mode = 2'd2;
        cmd_period = 8'd2;
        run(8);
        step();
        cmd_valid = 1'b0;
        run(10);
        issue(2'd3, 8'd1, 8'd4);
        run(4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(2);
        issue(2'd2, 8'd2, 8'd0);
        run(20);
        for (int i = 0; i < 1500; i++) begin
            cmd_valid = $urandom_range(0, 9) == 0;
            cmd_mode = 2'($urandom_range(0, 3));
            cmd_period = 8'($urandom_range(0, 4));
            cmd_count = 8'($urandom_range(0, 3));
            rst = $urandom_range(0, 199) == 0;
            step();
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        run(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
